// File: rtl/status_sync_pkg.sv
// rtl/status_sync_pkg.sv - shared defaults and stretch-mode encoding for status_sync
package status_sync_pkg;

    localparam int NUM_CH_DEFAULT      = 8;
    localparam int SYNC_STAGES_DEFAULT = 2;
    localparam int DB_W_DEFAULT        = 16;
    localparam int STR_W_DEFAULT       = 24;

    typedef enum logic {
        HOLD_AFTER_FALL = 1'b0,
        PULSE_ON_RISE   = 1'b1
    } stretch_mode_e;

endpackage

// File: rtl/status_sync_ch.sv
// rtl/status_sync_ch.sv - one status channel: synchroniser, debounce, edges, stretch, sticky
// Debounce counter is built only when STATUS_SYNC_DEBOUNCE_EN is defined.
module status_sync_ch
    import status_sync_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int DB_W        = DB_W_DEFAULT,
    parameter int STR_W       = STR_W_DEFAULT
) (
    input  logic             clk27,
    input  logic             clk_reset_n,
    input  logic             async_i,
    input  logic [DB_W-1:0]  db_len_i,
    input  logic [STR_W-1:0] stretch_len_i,
    input  logic             stretch_mode_i,
    input  logic             clear_i,
    output logic             sync_o,
    output logic             rise_o,
    output logic             fall_o,
    output logic             stretch_o,
    output logic             sticky_o
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              synced;
    logic              stable_q, stable_d;
    logic              prev_q;
    logic              sticky_q;
    logic              rise_nx, fall_nx;
    logic [STR_W-1:0]  str_cnt_q, str_cnt_d;
    stretch_mode_e     mode_q, mode_d, mode_live, mode_eff;

    assign synced    = sync_q[STAGES-1];
    assign mode_live = stretch_mode_e'(stretch_mode_i);

    always_ff @(posedge clk27 or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
        end
    end

`ifdef STATUS_SYNC_DEBOUNCE_EN
    logic [DB_W-1:0] db_cnt_q, db_cnt_d;
    logic            db_done;

    // db_cnt_q counts earlier differing cycles, so the current one completes the run
    assign db_done = ({1'b0, db_cnt_q} + (DB_W+1)'(1)) >= {1'b0, db_len_i};

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (synced != stable_q) begin
            if (db_done) begin
                stable_d = synced;
            end else if (db_cnt_q != '1) begin
                db_cnt_d = db_cnt_q + DB_W'(1);
            end else begin
                db_cnt_d = db_cnt_q;
            end
        end
    end

    always_ff @(posedge clk27 or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_d;
        end
    end
`else
    logic unused_db_len;
    assign unused_db_len = ^db_len_i;
    assign stable_d      = synced;
`endif

    assign rise_nx = stable_d & ~stable_q;
    assign fall_nx = ~stable_d & stable_q;

    // The count is loaded on the same edge that raises sync_o so stretch covers the rise cycle
    always_comb begin
        str_cnt_d = (str_cnt_q != '0) ? str_cnt_q - STR_W'(1) : '0;
        mode_d    = mode_q;
        if (rise_nx) begin
            if (mode_live == PULSE_ON_RISE) begin
                str_cnt_d = stretch_len_i;
                mode_d    = PULSE_ON_RISE;
            end else begin
                str_cnt_d = '0;
            end
        end else if (fall_nx && mode_live == HOLD_AFTER_FALL) begin
            str_cnt_d = stretch_len_i;
            mode_d    = HOLD_AFTER_FALL;
        end
    end

    always_ff @(posedge clk27 or negedge clk_reset_n) begin
        if (!clk_reset_n) begin
            stable_q  <= 1'b0;
            prev_q    <= 1'b0;
            str_cnt_q <= '0;
            mode_q    <= HOLD_AFTER_FALL;
            sticky_q  <= 1'b0;
        end else begin
            stable_q  <= stable_d;
            prev_q    <= stable_q;
            str_cnt_q <= str_cnt_d;
            mode_q    <= mode_d;
            if (rise_o) begin
                sticky_q <= 1'b1;
            end else if (clear_i) begin
                sticky_q <= 1'b0;
            end
        end
    end

    // A running count keeps the mode it was loaded with; an idle channel follows the input
    assign mode_eff  = (str_cnt_q == '0) ? mode_live : mode_q;

    assign sync_o    = stable_q;
    assign rise_o    = stable_q & ~prev_q;
    assign fall_o    = ~stable_q & prev_q;
    assign stretch_o = (str_cnt_q != '0) | (stable_q & (mode_eff == HOLD_AFTER_FALL));
    assign sticky_o  = sticky_q;

endmodule

// File: rtl/status_sync.sv
// rtl/status_sync.sv - NUM_CH status channels sharing debounce/stretch lengths
// Debounce is enabled with STATUS_SYNC_DEBOUNCE_EN; otherwise db_len_i is ignored.
module status_sync
    import status_sync_pkg::*;
#(
    parameter int NUM_CH      = NUM_CH_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
    parameter int DB_W        = DB_W_DEFAULT,
    parameter int STR_W       = STR_W_DEFAULT
) (
    input  logic              clk27,
    input  logic              clk_reset_n,
    input  logic [NUM_CH-1:0] async_i,
    input  logic [DB_W-1:0]   db_len_i,
    input  logic [STR_W-1:0]  stretch_len_i,
    input  logic [NUM_CH-1:0] stretch_mode_i,
    input  logic [NUM_CH-1:0] clear_i,
    output logic [NUM_CH-1:0] sync_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic [NUM_CH-1:0] stretch_o,
    output logic [NUM_CH-1:0] sticky_o
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        status_sync_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_W        (DB_W),
            .STR_W       (STR_W)
        ) u_ch (
            .clk27          (clk27),
            .clk_reset_n    (clk_reset_n),
            .async_i        (async_i[g]),
            .db_len_i       (db_len_i),
            .stretch_len_i  (stretch_len_i),
            .stretch_mode_i (stretch_mode_i[g]),
            .clear_i        (clear_i[g]),
            .sync_o         (sync_o[g]),
            .rise_o         (rise_o[g]),
            .fall_o         (fall_o[g]),
            .stretch_o      (stretch_o[g]),
            .sticky_o       (sticky_o[g])
        );
    end

endmodule
